bin_to_bcd_serial: RTL
======================

// Module: bin_to_bcd_serial
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
//  Sits directly upstream of the per-digit seven-segment decoders on DE2-115.
//  Each o_bcd nibble drives one decoder's 4-bit hex input; o_lz blanks leading zeros.
//  Holds the last result stable between conversions so the displays never flicker.
// PARAMETERS
//  IN_W    16  width of binary input (>=1)
//  DIGITS   5  number of BCD digits produced (>=1); 5 covers 16-bit unsigned
// PORTS
//  i_clk      in   1            system clock; single clock domain
//  i_rst_n    in   1            asynchronous active-low reset
//  i_start    in   1            request conversion of i_bin; sampled only in IDLE
//  i_bin      in   IN_W         unsigned binary value, captured on the accepted start
//  o_busy     out  1            high while a conversion is in progress
//  o_valid    out  1            1-cycle pulse when o_bcd/o_lz/o_ovf update
//  o_bcd      out  4*DIGITS     digit k at [4k+3:4k], k=0 least significant; each 0..9
//  o_lz       out  DIGITS       bit k=1: digit k is a leading zero (blank it); bit 0 always 0
//  o_ovf      out  1            last result did not fit in DIGITS (value >= 10**DIGITS)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; o_busy=0, o_valid=0, o_bcd=0,
//   o_lz={DIGITS-1{1'b1}},1'b0 (display shows "0"), o_ovf=0; internal regs cleared.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : i_start=1 at edge E -> capture i_bin in shift reg, clear BCD accumulator,
//          clear ovf, load bit counter with IN_W, go to SHIFT. o_busy=1 from E.
//   SHIFT: each cycle, every digit >=5 gets +3 (pre-shift adjust),
//          then {acc,bin} shifts left by 1. The bit leaving the top digit ORs into ovf.
//          Counter decrements; after IN_W shift cycles go to DONE.
//   DONE : register acc->o_bcd, compute o_lz, ovf->o_ovf; o_valid=1 for exactly
//          this one cycle; o_busy=0 from the following cycle; return to IDLE.
//  Latency: start accepted at edge E -> o_valid high in cycle after edge E+IN_W+1.
//   Back-to-back: i_start may be held high; the next conversion is accepted in the
//   IDLE cycle following DONE (throughput one result per IN_W+2 cycles).
//  i_start while o_busy=1: ignored, no queueing; i_bin changes mid-conversion ignored.
//  Overflow: o_bcd = value mod 10**DIGITS (low digits remain correct), o_ovf=1.
//  o_lz: bit k (k>=1) = 1 iff digits k..DIGITS-1 are all zero. Zero input -> "0" only.
//  o_bcd/o_lz/o_ovf change only in the DONE cycle; stable otherwise.
//  Reset mid-conversion: abort immediately, outputs return to reset values, no o_valid.
//  Counter width $clog2(IN_W+1); all adds are 4-bit per digit, no carry between digits
//   (adjusted digit <=12 fits 4 bits).
// STRUCTURE
//  Package dclab_display_pkg: typedef enum logic [1:0] {S_IDLE,S_SHIFT,S_DONE} b2b_state_t;
//   localparam BCD_W=4; function bcd_adj3(logic[3:0]) shared with other display stages.
//  Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instanced DIGITS
//   times via generate. FSM, counter, shift register and output regs stay in top.
// TESTING
//  1. i_bin=16'd0, start -> o_valid after 17 cycles, o_bcd=20'h00000, o_lz=5'b11110, o_ovf=0.
//  2. i_bin=16'd65535 -> o_bcd=20'h65535, o_lz=5'b00000, o_ovf=0; exact pulse timing checked.
//  3. IN_W=16,DIGITS=4, i_bin=16'd12345 -> o_bcd=16'h2345, o_ovf=1, o_lz=4'b0000.
//  4. i_bin=16'd907, then i_start pulsed and i_bin=16'd1 during SHIFT -> single o_valid,
//     o_bcd=20'h00907, o_lz=5'b11000; second start ignored.
//  5. Hold i_start=1, i_bin 42 then 43 -> valid pulses 18 cycles apart, 20'h00042, 20'h00043.
//  6. Assert i_rst_n=0 mid-SHIFT -> outputs at reset values same cycle, no o_valid;
//     after release a fresh 1234 conversion gives 20'h01234.
//  Plus random sweep of i_bin vs. reference model (mod 10**DIGITS, ovf, lz).

Source files
------------

// File: rtl/dclab_display_pkg.sv
// Shared types and helpers for the display pipeline stages.
// Used by the binary-to-BCD converter and the seven-segment drivers.
package dclab_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } b2b_state_t;

  localparam int BCD_W = 4;

  // Double-dabble pre-shift correction. A digit of 5..9 becomes 8..12,
  // so the result always fits in four bits.
  function automatic logic [BCD_W-1:0] bcd_adj3(input logic [BCD_W-1:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational per-digit "add 3 if >= 5" stage used by the serial converter.
module bcd_digit_adj
  import dclab_display_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  assign adj = bcd_adj3(digit);

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (double dabble), one input bit per clock.
// Results are held between conversions so downstream displays never flicker.
module bin_to_bcd_serial
  import dclab_display_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [IN_W-1:0]         i_bin,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic [DIGITS-1:0]       o_lz,
  output logic                    o_ovf
);

  // state   | meaning
  // S_IDLE  | waiting for i_start; outputs hold the last result
  // S_SHIFT | adjust-then-shift one input bit per cycle, IN_W cycles
  // S_DONE  | publish result, pulse o_valid, return to idle

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [DIGITS-1:0] LZ_RST = {DIGITS{1'b1}} << 1;

  b2b_state_t        state;
  logic [IN_W-1:0]   bin_sr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic [DIGITS-1:0] lz_next;
  logic              upper_zero;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc[BCD_W*k +: BCD_W]),
      .adj   (acc_adj[BCD_W*k +: BCD_W])
    );
  end

  // Digit k is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_next    = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (acc[BCD_W*k +: BCD_W] == '0);
      lz_next[k] = upper_zero;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      bin_sr  <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      o_lz    <= LZ_RST;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            bin_sr <= i_bin;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(IN_W);
            o_busy <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Anything pushed out of the top digit means the value needs more digits.
          acc    <= {acc_adj[ACC_W-2:0], bin_sr[IN_W-1]};
          bin_sr <= bin_sr << 1;
          ovf    <= ovf | acc_adj[ACC_W-1];
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          o_bcd   <= acc;
          o_lz    <= lz_next;
          o_ovf   <= ovf;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
